param_bus_datapath: RTL and testbench

- Parametrised single-bus CPU datapath: general-purpose register bank, PC, IR, Y, 2×W Z, HI, LO, MAR, MDR, in-port and out-port, all around one shared bus.
- Adds over the fixed 32-bit/16-register generation: configurable width and register count, registered multi-driver detection, an optional hard-wired-zero R0, and a memory read/write handshake FSM with timeout that owns MDR loads from memory.
- Sits between the control unit (drives enables) and the ALU/memory.

---
 rtl/param_bus_datapath_if.sv | 27 ++
 rtl/param_bus_datapath.sv | 176 +++++++++++++++++
 tb/tb_param_bus_datapath.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_bus_datapath_if.sv
// Memory-side handshake bundle for param_bus_datapath: command strobes in,
// request/status and MAR/MDR views out.
interface param_bus_datapath_if #(
  parameter int DATA_W = 32
);
  logic              mem_start_rd;
  logic              mem_start_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_err;

  modport master (
    input  mem_start_rd, mem_start_wr, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err
  );

  modport slave (
    output mem_start_rd, mem_start_wr, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err
  );
endinterface

// File: rtl/param_bus_datapath.sv
// Parametrised single-bus CPU datapath: register bank and special registers
// around one priority-muxed bus, plus a memory read/write FSM with timeout.
module param_bus_datapath #(
  parameter int DATA_W      = 32,
  parameter int NUM_GPR     = 16,
  parameter int R0_ZERO     = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NUM_GPR-1:0]    gpr_in,
  input  logic [NUM_GPR-1:0]    gpr_out,
  input  logic                  pc_in,
  input  logic                  ir_in,
  input  logic                  y_in,
  input  logic                  hi_in,
  input  logic                  lo_in,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  outport_in,
  input  logic                  z_in,
  input  logic                  pc_out,
  input  logic                  mdr_out,
  input  logic                  hi_out,
  input  logic                  lo_out,
  input  logic                  zhi_out,
  input  logic                  zlo_out,
  input  logic                  inport_out,
  input  logic                  c_out,
  input  logic [DATA_W-1:0]     c_data,
  input  logic [DATA_W-1:0]     inport_data,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic [DATA_W-1:0]     bus,
  output logic [DATA_W-1:0]     y_data,
  output logic [DATA_W-1:0]     ir_data,
  output logic [DATA_W-1:0]     pc_data,
  output logic [DATA_W-1:0]     outport_data,
  output logic                  bus_conflict,
  param_bus_datapath_if.master  mem
);

  localparam int DRV_W = NUM_GPR + 8;

  typedef enum logic [1:0] {IDLE, RD, WR} mem_state_t;

  mem_state_t        state, state_next;
  logic [7:0]        cnt, cnt_next;
  logic              done_q, done_next;
  logic              err_q, err_next;
  logic              mdr_from_mem;

  logic [DATA_W-1:0] gpr [NUM_GPR];
  logic [DATA_W-1:0] pc, ir, y, hi, lo, zhi, zlo, mar, mdr, outport;
  logic [DRV_W-1:0]  drv;
  logic              multi_drive;

  // Later assignments win, so sources are listed lowest priority first.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (gpr_out[i]) begin
        bus = (R0_ZERO != 0 && i == 0) ? '0 : gpr[i];
      end
    end
    if (hi_out)     bus = hi;
    if (lo_out)     bus = lo;
    if (zhi_out)    bus = zhi;
    if (zlo_out)    bus = zlo;
    if (pc_out)     bus = pc;
    if (mdr_out)    bus = mdr;
    if (inport_out) bus = inport_data;
    if (c_out)      bus = c_data;
  end

  assign drv = {gpr_out, hi_out, lo_out, zhi_out, zlo_out,
                pc_out, mdr_out, inport_out, c_out};
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_drive = (drv & (drv - DRV_W'(1))) != '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      pc           <= '0;
      ir           <= '0;
      y            <= '0;
      hi           <= '0;
      lo           <= '0;
      zhi          <= '0;
      zlo          <= '0;
      mar          <= '0;
      mdr          <= '0;
      outport      <= '0;
      bus_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (gpr_in[i]) gpr[i] <= bus;
      end
      if (pc_in)      pc      <= bus;
      if (ir_in)      ir      <= bus;
      if (y_in)       y       <= bus;
      if (hi_in)      hi      <= bus;
      if (lo_in)      lo      <= bus;
      if (mar_in)     mar     <= bus;
      if (outport_in) outport <= bus;
      if (z_in) begin
        zlo <= alu_result[DATA_W-1:0];
        zhi <= alu_result[2*DATA_W-1:DATA_W];
      end
      // A pending read owns MDR; bus loads are only honoured outside RD.
      if (mdr_from_mem)                mdr <= mem.mem_rdata;
      else if (mdr_in && state != RD)  mdr <= bus;
      bus_conflict <= multi_drive;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      done_q <= done_next;
      err_q  <= err_next;
    end
  end

  // An ack on the final counted cycle still completes rather than timing out.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    done_next    = 1'b0;
    err_next     = err_q;
    mdr_from_mem = 1'b0;
    case (state)
      IDLE: begin
        if (mem.mem_start_rd) begin
          state_next = RD;
          cnt_next   = '0;
        end else if (mem.mem_start_wr) begin
          state_next = WR;
          cnt_next   = '0;
        end
      end
      RD, WR: begin
        if (mem.mem_ack) begin
          state_next   = IDLE;
          done_next    = 1'b1;
          mdr_from_mem = (state == RD);
        end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_req   = (state != IDLE);
  assign mem.mem_we    = (state == WR);
  assign mem.mem_busy  = (state != IDLE);
  assign mem.mem_done  = done_q;
  assign mem.mem_err   = err_q;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;

  assign y_data       = y;
  assign ir_data      = ir;
  assign pc_data      = pc;
  assign outport_data = outport;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: two instances (R0 normal / R0 hard-zero)
// share stimulus; every expected value below is hand-computed.
module tb_param_bus_datapath;

  localparam int DW = 32;
  localparam int NG = 16;

  logic            clk = 1'b0;
  logic            clr;
  logic [NG-1:0]   gpr_in, gpr_out;
  logic            pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in, outport_in, z_in;
  logic            pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out, inport_out, c_out;
  logic [DW-1:0]   c_data, inport_data;
  logic [2*DW-1:0] alu_result;

  logic [DW-1:0]   bus, y_data, ir_data, pc_data, outport_data;
  logic            bus_conflict;
  logic [DW-1:0]   bus_z, y_z, ir_z, pc_z, outport_z;
  logic            conflict_z;

  int vectors     = 0;
  int miscompares = 0;

  param_bus_datapath_if #(.DATA_W(DW)) mem_if ();
  param_bus_datapath_if #(.DATA_W(DW)) mem_if_z ();

  assign mem_if_z.mem_start_rd = mem_if.mem_start_rd;
  assign mem_if_z.mem_start_wr = mem_if.mem_start_wr;
  assign mem_if_z.mem_rdata    = mem_if.mem_rdata;
  assign mem_if_z.mem_ack      = mem_if.mem_ack;

  param_bus_datapath #(.DATA_W(DW), .NUM_GPR(NG), .R0_ZERO(0), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .gpr_in(gpr_in), .gpr_out(gpr_out),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in), .z_in(z_in),
    .pc_out(pc_out), .mdr_out(mdr_out), .hi_out(hi_out), .lo_out(lo_out),
    .zhi_out(zhi_out), .zlo_out(zlo_out), .inport_out(inport_out), .c_out(c_out),
    .c_data(c_data), .inport_data(inport_data), .alu_result(alu_result),
    .bus(bus), .y_data(y_data), .ir_data(ir_data), .pc_data(pc_data),
    .outport_data(outport_data), .bus_conflict(bus_conflict), .mem(mem_if.master)
  );

  param_bus_datapath #(.DATA_W(DW), .NUM_GPR(NG), .R0_ZERO(1), .MEM_TIMEOUT(4)) dut_z (
    .clk(clk), .clr(clr), .gpr_in(gpr_in), .gpr_out(gpr_out),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in), .z_in(z_in),
    .pc_out(pc_out), .mdr_out(mdr_out), .hi_out(hi_out), .lo_out(lo_out),
    .zhi_out(zhi_out), .zlo_out(zlo_out), .inport_out(inport_out), .c_out(c_out),
    .c_data(c_data), .inport_data(inport_data), .alu_result(alu_result),
    .bus(bus_z), .y_data(y_z), .ir_data(ir_z), .pc_data(pc_z),
    .outport_data(outport_z), .bus_conflict(conflict_z), .mem(mem_if_z.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_enables();
    gpr_in = '0; gpr_out = '0;
    pc_in = 0; ir_in = 0; y_in = 0; hi_in = 0; lo_in = 0; mar_in = 0; mdr_in = 0;
    outport_in = 0; z_in = 0;
    pc_out = 0; mdr_out = 0; hi_out = 0; lo_out = 0; zhi_out = 0; zlo_out = 0;
    inport_out = 0; c_out = 0;
  endtask

  task automatic load_const(input logic [DW-1:0] val);
    c_data = val;
    c_out  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clr = 1'b0;
    clear_enables();
    c_data = '0; inport_data = 32'hA5A5_0001; alu_result = '0;
    mem_if.mem_start_rd = 0; mem_if.mem_start_wr = 0;
    mem_if.mem_ack = 0; mem_if.mem_rdata = '0;
    #2;
    check("reset_bus", bus, 0);
    check("reset_pc", pc_data, 0);
    check("reset_conflict", bus_conflict, 0);
    check("reset_req", mem_if.mem_req, 0);
    check("reset_err", mem_if.mem_err, 0);
    check("reset_outport", outport_data, 0);
    tick();
    clr = 1'b1;

    // Constant into R5, then R5 back onto the bus
    load_const(32'h0000_1234); gpr_in[5] = 1'b1; #1;
    check("c_out_bus", bus, 32'h1234);
    tick(); clear_enables();
    gpr_out[5] = 1'b1; #1;
    check("r5_bus", bus, 32'h1234);
    tick();
    check("r5_no_conflict", bus_conflict, 0);
    clear_enables();

    // R0 write; hard-zero instance must still drive 0
    load_const(32'hDEAD_BEEF); gpr_in[0] = 1'b1;
    tick(); clear_enables();
    gpr_out[0] = 1'b1; #1;
    check("r0_normal_bus", bus, 32'hDEAD_BEEF);
    check("r0_zero_bus", bus_z, 0);
    tick(); clear_enables();

    // PC=0x40, R3=0x99, then both drive: PC wins, conflict flagged one cycle
    load_const(32'h40); pc_in = 1'b1;
    tick(); clear_enables();
    check("pc_load", pc_data, 32'h40);
    load_const(32'h99); gpr_in[3] = 1'b1;
    tick(); clear_enables();
    pc_out = 1'b1; gpr_out[3] = 1'b1; #1;
    check("pc_over_r3_bus", bus, 32'h40);
    check("conflict_not_yet", bus_conflict, 0);
    tick(); clear_enables();
    check("conflict_set", bus_conflict, 1);
    check("conflict_set_z", conflict_z, 1);
    tick();
    check("conflict_clear", bus_conflict, 0);

    // Multi-load, inport priority, Z halves
    load_const(32'h77); outport_in = 1'b1; y_in = 1'b1; ir_in = 1'b1;
    tick(); clear_enables();
    check("outport_load", outport_data, 32'h77);
    check("y_load", y_data, 32'h77);
    check("ir_load", ir_data, 32'h77);
    inport_out = 1'b1; pc_out = 1'b1; #1;
    check("inport_over_pc", bus, 32'hA5A5_0001);
    clear_enables();
    alu_result = 64'h1111_2222_3333_4444; z_in = 1'b1;
    tick(); clear_enables();
    zlo_out = 1'b1; #1;
    check("zlo_bus", bus, 32'h3333_4444);
    zlo_out = 1'b0; zhi_out = 1'b1; #1;
    check("zhi_bus", bus, 32'h1111_2222);
    clear_enables();

    // MAR=0x10, MDR=0x55, read with ack in the third cycle
    load_const(32'h10); mar_in = 1'b1;
    tick(); clear_enables();
    check("mar_addr", mem_if.mem_addr, 32'h10);
    load_const(32'h55); mdr_in = 1'b1;
    tick(); clear_enables();
    check("mdr_wdata", mem_if.mem_wdata, 32'h55);
    mem_if.mem_start_rd = 1'b1;
    tick(); mem_if.mem_start_rd = 1'b0;
    check("rd_req_c1", mem_if.mem_req, 1);
    check("rd_we", mem_if.mem_we, 0);
    check("rd_busy", mem_if.mem_busy, 1);
    load_const(32'h1); mdr_in = 1'b1;
    tick(); clear_enables();
    check("rd_req_c2", mem_if.mem_req, 1);
    check("rd_mdr_in_ignored", mem_if.mem_wdata, 32'h55);
    tick();
    check("rd_req_c3", mem_if.mem_req, 1);
    check("rd_done_early", mem_if.mem_done, 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
    tick(); mem_if.mem_ack = 1'b0;
    check("rd_req_drop", mem_if.mem_req, 0);
    check("rd_done", mem_if.mem_done, 1);
    check("rd_mdr", mem_if.mem_wdata, 32'hCAFE_F00D);
    tick();
    check("rd_done_pulse", mem_if.mem_done, 0);

    // Ack while idle is ignored
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hBAD0_BAD0;
    tick(); mem_if.mem_ack = 1'b0;
    check("idle_ack_busy", mem_if.mem_busy, 0);
    check("idle_ack_done", mem_if.mem_done, 0);
    check("idle_ack_mdr", mem_if.mem_wdata, 32'hCAFE_F00D);

    // Write with no ack: times out after four cycles
    load_const(32'h55); mdr_in = 1'b1;
    tick(); clear_enables();
    mem_if.mem_start_wr = 1'b1;
    tick(); mem_if.mem_start_wr = 1'b0;
    check("wr_req_c1", mem_if.mem_req, 1);
    check("wr_we", mem_if.mem_we, 1);
    load_const(32'h66); mdr_in = 1'b1;
    tick(); clear_enables();
    check("wr_mdr_in_honoured", mem_if.mem_wdata, 32'h66);
    check("wr_req_c2", mem_if.mem_req, 1);
    tick();
    check("wr_req_c3", mem_if.mem_req, 1);
    tick();
    check("wr_req_c4", mem_if.mem_req, 1);
    check("wr_err_early", mem_if.mem_err, 0);
    tick();
    check("wr_timeout_req", mem_if.mem_req, 0);
    check("wr_timeout_err", mem_if.mem_err, 1);
    check("wr_timeout_done", mem_if.mem_done, 0);
    check("wr_timeout_mdr", mem_if.mem_wdata, 32'h66);
    tick();
    check("wr_done_never", mem_if.mem_done, 0);

    // Both strobes: read wins; completes normally, error stays sticky
    mem_if.mem_start_rd = 1'b1; mem_if.mem_start_wr = 1'b1;
    tick(); mem_if.mem_start_rd = 1'b0; mem_if.mem_start_wr = 1'b0;
    check("both_req", mem_if.mem_req, 1);
    check("both_read_wins", mem_if.mem_we, 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h1234_5678;
    tick(); mem_if.mem_ack = 1'b0;
    check("rd2_done", mem_if.mem_done, 1);
    check("rd2_mdr", mem_if.mem_wdata, 32'h1234_5678);
    check("err_sticky", mem_if.mem_err, 1);

    // Asynchronous reset mid-read with conflict flag set
    mem_if.mem_start_rd = 1'b1; pc_out = 1'b1; gpr_out[3] = 1'b1;
    tick(); mem_if.mem_start_rd = 1'b0; clear_enables();
    check("pre_reset_busy", mem_if.mem_busy, 1);
    check("pre_reset_conflict", bus_conflict, 1);
    #1 clr = 1'b0;
    #1;
    check("async_req", mem_if.mem_req, 0);
    check("async_busy", mem_if.mem_busy, 0);
    check("async_mdr", mem_if.mem_wdata, 0);
    check("async_conflict", bus_conflict, 0);
    check("async_err", mem_if.mem_err, 0);
    check("async_pc", pc_data, 0);
    tick();
    clr = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
